// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the iterative CORDIC cosine core:
//   - datapath width and fractional bit count (signed Q2.30)
//   - FSM state encoding
//   - CORDIC gain constant K in Q30
//   - arctangent table atan(2^-k) * 2^30, k = 0..23, rounded to nearest
// No ports (package).
// -----------------------------------------------------------------------------
package cordic_pkg;

   localparam int DATA_W   = 32;
   localparam int FRAC     = 30;
   localparam int MAX_ITER = 24;
   localparam int IDX_W    = 5;   // wide enough to count to MAX_ITER

   // 0.6072529350 * 2^30: pre-scaling so the final x needs no gain correction
   localparam logic signed [31:0] K_Q30 = 32'sd652032874;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cordic_state_e;

   function automatic logic signed [31:0] atan_q30(input logic [IDX_W-1:0] k);
      logic signed [31:0] v;
      case (k)
         5'd0:    v = 32'sd843314857;
         5'd1:    v = 32'sd497837829;
         5'd2:    v = 32'sd263043837;
         5'd3:    v = 32'sd133525159;
         5'd4:    v = 32'sd67021687;
         5'd5:    v = 32'sd33543516;
         5'd6:    v = 32'sd16775851;
         5'd7:    v = 32'sd8388437;
         5'd8:    v = 32'sd4194283;
         5'd9:    v = 32'sd2097149;
         5'd10:   v = 32'sd1048576;
         5'd11:   v = 32'sd524288;
         5'd12:   v = 32'sd262144;
         5'd13:   v = 32'sd131072;
         5'd14:   v = 32'sd65536;
         5'd15:   v = 32'sd32768;
         5'd16:   v = 32'sd16384;
         5'd17:   v = 32'sd8192;
         5'd18:   v = 32'sd4096;
         5'd19:   v = 32'sd2048;
         5'd20:   v = 32'sd1024;
         5'd21:   v = 32'sd512;
         5'd22:   v = 32'sd256;
         5'd23:   v = 32'sd128;
         default: v = 32'sd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/cordic_iter_core_if.sv
// -----------------------------------------------------------------------------
// cordic_iter_core_if
// Custom-instruction handshake bundle for cordic_iter_core.
//   clk_en  : global enable; when low the core holds every register
//   start   : request; accepted only on an edge with clk_en=1 while IDLE
//   dataa   : angle, signed Q2.30, captured on the accepting edge
//   result  : cos(angle), signed Q2.30, registered, valid while done=1
//   done    : high while the core is in DONE (held through clk_en stalls)
//   busy    : high in RUN and DONE
//   state   : debug view of the FSM state
//
// Handshake: start acts as valid and (state==IDLE && clk_en) as ready; a
// start seen while not ready is dropped, never queued. done is the response
// valid and has no back-pressure: it drops on the next enabled edge.
// Modports: master = requester (drives clk_en/start/dataa), slave = core.
// -----------------------------------------------------------------------------
interface cordic_iter_core_if #(
   parameter int DATA_W = cordic_pkg::DATA_W
);
   import cordic_pkg::*;

   logic              clk_en;
   logic              start;
   logic [DATA_W-1:0] dataa;
   logic [DATA_W-1:0] result;
   logic              done;
   logic              busy;
   cordic_state_e     state;

   modport master (
      output clk_en, start, dataa,
      input  result, done, busy, state
   );

   modport slave (
      input  clk_en, start, dataa,
      output result, done, busy, state
   );

endinterface

// File: rtl/cordic_stage.sv
// -----------------------------------------------------------------------------
// cordic_stage
// One combinational rotation-mode CORDIC micro-rotation for index k.
//   x_i, y_i, z_i : current vector and residual angle (signed Q2.30)
//   k_i           : micro-rotation index (shift amount, atan table index)
//   x_o, y_o, z_o : rotated vector and updated residual angle
// Direction follows the sign of z_i: rotate positive when z_i >= 0.
// Arithmetic shifts truncate toward -inf; sums wrap in two's complement.
// -----------------------------------------------------------------------------
module cordic_stage #(
   parameter int DATA_W = cordic_pkg::DATA_W
) (
   input  logic signed [DATA_W-1:0]           x_i,
   input  logic signed [DATA_W-1:0]           y_i,
   input  logic signed [DATA_W-1:0]           z_i,
   input  logic        [cordic_pkg::IDX_W-1:0] k_i,
   output logic signed [DATA_W-1:0]           x_o,
   output logic signed [DATA_W-1:0]           y_o,
   output logic signed [DATA_W-1:0]           z_o
);
   import cordic_pkg::*;

   logic signed [DATA_W-1:0] x_sh;
   logic signed [DATA_W-1:0] y_sh;
   logic signed [DATA_W-1:0] atan_k;

   assign x_sh   = x_i >>> k_i;
   assign y_sh   = y_i >>> k_i;
   assign atan_k = DATA_W'(atan_q30(k_i));

   always_comb begin
      if (z_i[DATA_W-1]) begin
         // d = -1
         x_o = x_i + y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atan_k;
      end else begin
         // d = +1
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atan_k;
      end
   end

endmodule

// File: rtl/cordic_iter_core.sv
// -----------------------------------------------------------------------------
// cordic_iter_core
// Iterative rotation-mode CORDIC computing cos(angle) in signed Q2.30.
// Performs UNROLL chained micro-rotations per enabled clock, ITER in total.
//   clock : rising-edge clock
//   reset : synchronous active-low reset, wins over clk_en
//   io    : handshake bundle (slave side), see cordic_iter_core_if
// Parameters: DATA_W datapath width, ITER total micro-rotations (1..24,
// multiple of UNROLL), UNROLL micro-rotations per clock (1, 2 or 4).
// Latency: ITER/UNROLL+1 enabled edges from accepting start to done=1.
// -----------------------------------------------------------------------------
module cordic_iter_core #(
   parameter int DATA_W = cordic_pkg::DATA_W,
   parameter int ITER   = 16,
   parameter int UNROLL = 1
) (
   input logic                clock,
   input logic                reset,
   cordic_iter_core_if.slave  io
);
   import cordic_pkg::*;

   cordic_state_e            state_q,  state_d;
   logic signed [DATA_W-1:0] x_q,      x_d;
   logic signed [DATA_W-1:0] y_q,      y_d;
   logic signed [DATA_W-1:0] z_q,      z_d;
   logic signed [DATA_W-1:0] result_q, result_d;
   logic        [IDX_W-1:0]  i_q,      i_d;
   logic                     done_q,   done_d;
   logic                     busy_q,   busy_d;

   logic        [IDX_W-1:0]  i_next;

   // Micro-rotation chain: element 0 is the registered state, element
   // UNROLL is the state after this clock's rotations.
   logic signed [DATA_W-1:0] cx [UNROLL+1];
   logic signed [DATA_W-1:0] cy [UNROLL+1];
   logic signed [DATA_W-1:0] cz [UNROLL+1];

   assign cx[0] = x_q;
   assign cy[0] = y_q;
   assign cz[0] = z_q;

   for (genvar j = 0; j < UNROLL; j++) begin : g_stage
      cordic_stage #(
         .DATA_W (DATA_W)
      ) u_stage (
         .x_i (cx[j]),
         .y_i (cy[j]),
         .z_i (cz[j]),
         .k_i (i_q + IDX_W'(j)),
         .x_o (cx[j+1]),
         .y_o (cy[j+1]),
         .z_o (cz[j+1])
      );
   end

   assign i_next = i_q + IDX_W'(UNROLL);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      i_d      = i_q;
      result_d = result_q;
      done_d   = done_q;
      busy_d   = busy_q;

      case (state_q)
         IDLE: begin
            if (io.start) begin
               x_d     = DATA_W'(K_Q30);
               y_d     = '0;
               z_d     = io.dataa;
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            x_d = cx[UNROLL];
            y_d = cy[UNROLL];
            z_d = cz[UNROLL];
            i_d = i_next;
            // Last batch of rotations: publish x directly from the chain so
            // result lands on the same edge that enters DONE.
            if (i_next == IDX_W'(ITER)) begin
               result_d = cx[UNROLL];
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            // Any start seen here is dropped; IDLE must be reached first.
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         i_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else if (io.clk_en) begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         i_q      <= i_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign io.result = result_q;
   assign io.done   = done_q;
   assign io.busy   = busy_q;
   assign io.state  = state_q;

endmodule
